// File: rtl/mem_bist_pkg.sv
// Shared FSM encoding and phase helpers for the memory BIST controller.
// MEM_BIST_INV_PASS_EN adds the inverted-pattern WR1/RD1 passes.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } bist_state_e;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int NUM_PHASES = 4;
`else
  localparam int NUM_PHASES = 2;
`endif

  // Phase that follows a completed sweep; the last sweep lands in DONE.
  function automatic bist_state_e next_phase(input bist_state_e s);
    case (s)
      WR0:     next_phase = RD0;
`ifdef MEM_BIST_INV_PASS_EN
      RD0:     next_phase = WR1;
      WR1:     next_phase = RD1;
`endif
      default: next_phase = DONE;
    endcase
  endfunction

  function automatic logic is_write(input bist_state_e s);
    is_write = (s == WR0) || (s == WR1);
  endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Test pattern: address zero-extended/truncated to the data width, optionally inverted.
module mem_bist_pattern #(
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  inv_i,
  output logic [WIDTH-1:0]      data_o
);

  logic [WIDTH-1:0] base;

  always_comb begin
    base   = WIDTH'(addr_i);
    data_o = inv_i ? ~base : base;
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write/read sweeps with stop-on-first-fail capture.
// Define MEM_BIST_INV_PASS_EN to add the inverted WR1/RD1 passes.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic [WIDTH-1:0]      err_exp_o,
  output logic [WIDTH-1:0]      err_act_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  bist_state_e           state_q, state_d, nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [WIDTH-1:0]      err_exp_q, err_exp_d, err_act_q, err_act_d;
  logic                  valid_q, valid_d, busy_q, busy_d;
  logic                  done_q, done_d, fail_q, fail_d;
  logic [WIDTH-1:0]      pat;
  logic                  inv, xfer;

`ifdef MEM_BIST_INV_PASS_EN
  assign inv = (state_q == WR1) || (state_q == RD1);
`else
  assign inv = 1'b0;
`endif

  mem_bist_pattern #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pattern (
    .addr_i (addr_q),
    .inv_i  (inv),
    .data_o (pat)
  );

  // Ready is meaningless without an outstanding request.
  assign xfer = valid_q & mem_ready_i;
  assign nxt  = next_phase(state_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = WR0;
          addr_d     = '0;
          valid_d    = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
        end
      end
      default: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (xfer) begin
          valid_d = 1'b0;
          if (!is_write(state_q) && (mem_rdata_i != pat)) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            fail_d     = 1'b1;
            err_addr_d = addr_q;
            err_exp_d  = pat;
            err_act_d  = mem_rdata_i;
          end else if (addr_q == LAST_ADDR) begin
            state_d = nxt;
            addr_d  = '0;
            if (nxt == DONE) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign fail_o         = fail_q;
  assign err_addr_o     = err_addr_q;
  assign err_exp_o      = err_exp_q;
  assign err_act_o      = err_act_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = pat;
  assign mem_valid_o    = valid_q;
  assign mem_wr_rd_en_o = is_write(state_q);

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomized bench: memory model with stuck-at faults and backpressure, checked against a sweep-level model.
module tb_mem_bist_ctrl;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int NPH = 4;
`else
  localparam int NPH = 2;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, fail_o;
  logic [3:0] err_addr_o, err_exp_o, err_act_o;
  logic [3:0] mem_wdata_o, mem_addr_o, mem_rdata_i;
  logic       mem_valid_o, mem_wr_rd_en_o;
  logic       rdy;

  mem_bist_ctrl dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .fail_o         (fail_o),
    .err_addr_o     (err_addr_o),
    .err_exp_o      (err_exp_o),
    .err_act_o      (err_act_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_addr_o     (mem_addr_o),
    .mem_valid_o    (mem_valid_o),
    .mem_wr_rd_en_o (mem_wr_rd_en_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (rdy)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: stuck-at cell, random ready, optional 7-cycle stall on WR0 addr 9.
  logic [3:0] mem [16];
  bit         flt_en = 0, rnd_en = 0, bp_en = 0, bp_used;
  int         flt_a = 0, flt_b = 0, flt_v = 0, bp_cnt;

  assign mem_rdata_i = mem[mem_addr_o];

  function automatic logic [3:0] stuck(input int a, input logic [3:0] d);
    logic [3:0] m;
    m = 4'(1 << flt_b);
    if (flt_en && a == flt_a) return flt_v != 0 ? (d | m) : (d & ~m);
    return d;
  endfunction

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy <= 1'b0; bp_cnt <= 0; bp_used <= 1'b0;
    end else begin
      if (!bp_en) begin bp_used <= 1'b0; bp_cnt <= 0; end
      if (mem_valid_o && rdy) begin
        rdy <= 1'b0;
        if (mem_wr_rd_en_o) mem[mem_addr_o] <= stuck(int'(mem_addr_o), mem_wdata_o);
      end else if (mem_valid_o) begin
        if (bp_en && !bp_used && mem_addr_o == 4'd9 && mem_wr_rd_en_o) begin
          if (bp_cnt == 6) begin rdy <= 1'b1; bp_used <= 1'b1; end
          else bp_cnt <= bp_cnt + 1;
        end else if (rnd_en) rdy <= ($urandom_range(0, 2) == 0);
        else rdy <= 1'b1;
      end else rdy <= 1'b0;
    end
  end

  // Reference: expected transfer list and first-failure outcome, per sweep.
  typedef struct packed { logic wr; logic [3:0] addr; logic [3:0] data; } xfer_t;
  xfer_t      expq[$];
  int         n_exp;
  bit         e_fail;
  logic [3:0] e_addr, e_exp, e_act;

  task automatic build_model();
    logic [3:0] d, st;
    expq.delete();
    e_fail = 0; e_addr = 0; e_exp = 0; e_act = 0;
    for (int p = 0; p < NPH; p++) begin
      for (int a = 0; a < 16; a++) begin
        d = (p >= 2) ? ~4'(a) : 4'(a);
        expq.push_back('{wr: (p % 2 == 0), addr: 4'(a), data: d});
        st = stuck(a, d);
        if (p % 2 == 1 && st != d) begin
          e_fail = 1; e_addr = 4'(a); e_exp = d; e_act = st;
          n_exp = expq.size();
          return;
        end
      end
    end
    n_exp = expq.size();
  endtask

  int xfers = 0, stall_n = 0;
  bit any_valid = 0;

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (mem_valid_o) any_valid = 1;
      if (mem_valid_o && !rdy && bp_en && !bp_used && mem_addr_o == 4'd9 && mem_wr_rd_en_o) begin
        stall_n++;
        chk("bp_addr", mem_addr_o, 9);
        chk("bp_wdata", mem_wdata_o, 9);
      end
      if (mem_valid_o && rdy) begin
        xfer_t e;
        xfers++;
        if (expq.size() == 0) chk("extra_xfer", 1, 0);
        else begin
          e = expq.pop_front();
          chk("xfer_wr", mem_wr_rd_en_o, e.wr);
          chk("xfer_addr", mem_addr_o, e.addr);
          if (e.wr) chk("xfer_wdata", mem_wdata_o, e.data);
          else chk("xfer_rdata", mem_rdata_i, stuck(int'(e.addr), e.data));
        end
      end
    end
  end

  task automatic kick();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_done", done_o, 0);
    chk("start_fail_clr", fail_o, 0);
    chk("start_err_clr", {err_addr_o, err_exp_o, err_act_o}, 0);
    chk("start_valid_lat0", mem_valid_o, 0);
    @(negedge clk_i);
    chk("start_valid_lat1", mem_valid_o, 1);
    chk("start_addr0", mem_addr_o, 0);
  endtask

  task automatic run(input string nm, input bit restart);
    int cyc;
    build_model();
    xfers = 0;
    kick();
    cyc = 2;
    while (!done_o && cyc < 3000) begin
      @(negedge clk_i); cyc++;
      if (restart && cyc == 10) start_i = 1'b1;
      if (restart && cyc == 11) start_i = 1'b0;
    end
    start_i = 1'b0;
    chk({nm, "_done"}, done_o, 1);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_fail"}, fail_o, e_fail);
    chk({nm, "_err"}, {err_addr_o, err_exp_o, err_act_o}, {e_addr, e_exp, e_act});
    chk({nm, "_count"}, xfers, n_exp);
    chk({nm, "_left"}, expq.size(), 0);
    any_valid = 0;
    repeat (6) @(negedge clk_i);
    chk({nm, "_quiet"}, any_valid, 0);
    chk({nm, "_hold_done"}, done_o, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    #1;
    chk("rst_outs", {busy_o, done_o, fail_o, mem_valid_o, mem_wr_rd_en_o}, 0);
    chk("rst_bus", {err_addr_o, err_exp_o, err_act_o, mem_addr_o, mem_wdata_o}, 0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_no_req", any_valid, 0);

    run("clean", 0);

    flt_en = 1; flt_a = 5; flt_b = 2; flt_v = 0;
    run("stuck5", 0);
    chk("stuck5_act", err_act_o, 4'h1);
    chk("stuck5_count", xfers, 22);
    flt_en = 0;

    run("after_fail", 0);

    bp_en = 1; stall_n = 0;
    run("bp", 0);
    chk("bp_stalls", stall_n, 7);
    bp_en = 0;

    run("restart", 1);

    rnd_en = 1;
    for (int k = 0; k < 6; k++) begin
      flt_en = ($urandom_range(0, 1) == 1);
      flt_a = $urandom_range(0, 15); flt_b = $urandom_range(0, 3); flt_v = $urandom_range(0, 1);
      run("rand", 0);
    end
    flt_en = 0; rnd_en = 0;

    // Reset in the middle of a run (WR1 when enabled, else RD0).
    build_model(); xfers = 0;
    kick();
    for (int c = 0; c < 2000 && xfers < NPH * 10; c++) @(negedge clk_i);
    chk("mid_reached", xfers >= NPH * 10, 1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_outs", {busy_o, done_o, fail_o, mem_valid_o, mem_wr_rd_en_o}, 0);
    chk("mid_rst_bus", {err_addr_o, err_exp_o, err_act_o, mem_addr_o, mem_wdata_o}, 0);
    expq.delete();
    @(negedge clk_i); rst_n_i = 1'b1;
    any_valid = 0;
    repeat (20) @(negedge clk_i);
    chk("mid_no_req", any_valid, 0);
    chk("mid_idle", {busy_o, done_o}, 0);
    run("post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
